wbc_slave_arbiter: RTL and testbench

- Shares one classic (non-pipelined) Wishbone slave port between NM classic Wishbone masters, e.g. the CPU data bus and a future USB/DMA master contending for SRAM.
- Round-robin grant. Grant is held for a whole CYC burst.
- A bus-timeout watchdog errors out a hung slave so no master can lock the shared resource.
- Sits between the crossbar slave port (or the master buses) and a single peripheral such as the SRAM.

---
 rtl/wbc_slave_arbiter_pkg.sv | 23 ++
 rtl/wbc_slave_arbiter_rr_pick.sv | 32 +++
 rtl/wbc_slave_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wbc_slave_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbc_slave_arbiter_pkg.sv
// Shared definitions for the classic Wishbone slave-port arbiter: state
// encodings and the width helpers used by the top and the round-robin picker.
package wbc_slave_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  function automatic int wb_sel_w(input int dw);
    return dw / 8;
  endfunction

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold values up to n.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/wbc_slave_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
// Also used by the DMA scheduler, so it carries no state of its own.
module wbc_slave_arbiter_rr_pick
  import wbc_slave_arbiter_pkg::*;
#(
  parameter  int NM = 2,
  localparam int IW = idx_w(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic [NM-1:0] win_o,
  output logic [IW-1:0] win_idx_o,
  output logic          valid_o
);

  always_comb begin : pick
    int cand;
    win_o     = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NM; k++) begin
      cand = (int'(last_i) + k) % NM;
      if (!valid_o && req_i[cand]) begin
        win_o[cand] = 1'b1;
        win_idx_o   = IW'(cand);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbc_slave_arbiter.sv
// Shares one classic Wishbone slave port between NM masters: round-robin grant
// held for a whole CYC burst, with a watchdog that errors out a hung slave.
module wbc_slave_arbiter
  import wbc_slave_arbiter_pkg::*;
#(
  parameter  int NM      = 2,
  parameter  int AW      = 30,
  parameter  int DW      = 32,
  parameter  int TIMEOUT = 255,
  localparam int SW      = wb_sel_w(DW),
  localparam int IW      = idx_w(NM),
  localparam int TW      = cnt_w(TIMEOUT)
) (
  input  logic             wb_clk_i,
  input  logic             wb_reset_ni,
  input  logic [NM-1:0]    i_mcyc,
  input  logic [NM-1:0]    i_mstb,
  input  logic [NM-1:0]    i_mwe,
  input  logic [NM*AW-1:0] i_maddr,
  input  logic [NM*DW-1:0] i_mdata,
  input  logic [NM*SW-1:0] i_msel,
  output logic [NM-1:0]    o_mack,
  output logic [NM-1:0]    o_merr,
  output logic [NM*DW-1:0] o_mdata,
  output logic             o_scyc,
  output logic             o_sstb,
  output logic             o_swe,
  output logic [AW-1:0]    o_saddr,
  output logic [DW-1:0]    o_sdata,
  output logic [SW-1:0]    o_ssel,
  input  logic             i_sack,
  input  logic             i_serr,
  input  logic [DW-1:0]    i_sdata,
  output logic [NM-1:0]    o_grant,
  output logic             o_timeout
);

  logic [1:0]    state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tout_q, tout_d;

  logic [NM-1:0] req;
  logic [NM-1:0] pick_win;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;

  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_data;
  logic [SW-1:0] own_sel;

  logic          busy, abort, stall;

  assign req = i_mcyc & i_mstb;

  wbc_slave_arbiter_rr_pick #(
    .NM (NM)
  ) u_pick (
    .req_i     (req),
    .last_i    (owner_q),
    .win_o     (pick_win),
    .win_idx_o (pick_idx),
    .valid_o   (pick_vld)
  );

  // One-hot grant mux; with no grant everything reads as zero.
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    own_sel  = '0;
    for (int m = 0; m < NM; m++) begin
      if (grant_q[m]) begin
        own_cyc  = i_mcyc[m];
        own_stb  = i_mstb[m];
        own_we   = i_mwe[m];
        own_addr = i_maddr[m*AW +: AW];
        own_data = i_mdata[m*DW +: DW];
        own_sel  = i_msel[m*SW +: SW];
      end
    end
  end

  assign busy  = (state_q == ST_BUSY);
  assign abort = (state_q == ST_ABORT);
  assign stall = o_sstb & ~i_sack & ~i_serr;

  assign o_scyc    = busy & own_cyc;
  assign o_sstb    = busy & own_stb;
  assign o_swe     = busy & own_we;
  assign o_ssel    = busy ? own_sel : '0;
  assign o_saddr   = own_addr;
  assign o_sdata   = own_data;
  assign o_mdata   = {NM{i_sdata}};
  assign o_grant   = grant_q;
  assign o_timeout = tout_q;

  // Responses go only to the owner; during ABORT the slave is ignored and the
  // owner sees a single synthetic error on the first cycle.
  always_comb begin
    o_mack = '0;
    o_merr = '0;
    if (busy) begin
      o_mack = grant_q & {NM{i_sack}};
      o_merr = grant_q & {NM{i_serr}};
    end else if (abort && tout_q) begin
      o_merr = grant_q;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    tcnt_d  = '0;
    tout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BUSY;
          grant_d = pick_win;
          owner_d = pick_idx;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (stall) begin
          // Leave on the edge ending the (TIMEOUT-1)-th unanswered cycle so
          // the master is errored in its TIMEOUT-th cycle.
          if (TIMEOUT != 0 && (int'(tcnt_q) + 1) >= TIMEOUT - 1) begin
            state_d = ST_ABORT;
            tout_d  = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= IW'(NM - 1);
      tcnt_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      tcnt_q  <= tcnt_d;
      tout_q  <= tout_d;
    end
  end

endmodule

// File: tb/tb_wbc_slave_arbiter.sv
// Bench for wbc_slave_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the arbitration rules.
module tb_wbc_slave_arbiter;

  localparam int NM = 2;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int SW = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM-1:0]    mcyc, mstb, mwe;
  logic [NM*AW-1:0] maddr;
  logic [NM*DW-1:0] mdata_w;
  logic [NM*SW-1:0] msel;
  logic [NM-1:0]    mack, merr;
  logic [NM*DW-1:0] mdata_r;
  logic             scyc, sstb, swe;
  logic [AW-1:0]    saddr;
  logic [DW-1:0]    sdata_w;
  logic [SW-1:0]    ssel;
  logic             sack, serr;
  logic [DW-1:0]    sdata_r;
  logic [NM-1:0]    grant;
  logic             tout;

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = nobody), last winner, stalled-cycle count.
  int            m_owner, m_last, m_wait;
  bit            m_abort, m_first;
  logic [NM-1:0] e_grant, e_mack, e_merr;
  logic          e_scyc, e_sstb, e_tout;

  always #5 clk = ~clk;

  wbc_slave_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_reset_ni(rst_n),
    .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe), .i_maddr(maddr),
    .i_mdata(mdata_w), .i_msel(msel),
    .o_mack(mack), .o_merr(merr), .o_mdata(mdata_r),
    .o_scyc(scyc), .o_sstb(sstb), .o_swe(swe), .o_saddr(saddr),
    .o_sdata(sdata_w), .o_ssel(ssel),
    .i_sack(sack), .i_serr(serr), .i_sdata(sdata_r),
    .o_grant(grant), .o_timeout(tout)
  );

  task automatic model_reset();
    m_owner = -1; m_last = NM - 1; m_wait = 0; m_abort = 0; m_first = 0;
  endtask

  task automatic model_expect();
    e_grant = '0; e_mack = '0; e_merr = '0;
    e_scyc = 1'b0; e_sstb = 1'b0; e_tout = 1'b0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      if (!m_abort) begin
        e_scyc = mcyc[m_owner];
        e_sstb = mstb[m_owner];
        e_mack[m_owner] = sack;
        e_merr[m_owner] = serr;
      end else if (m_first) begin
        e_merr[m_owner] = 1'b1;
        e_tout = 1'b1;
      end
    end
  endtask

  // Advance the model over the coming clock edge using the present inputs.
  task automatic model_step();
    logic [NM-1:0] req;
    int c;
    req = mcyc & mstb;
    if (m_owner < 0) begin
      for (int k = 1; k <= NM; k++) begin
        c = (m_last + k) % NM;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_last  = c;
        end
      end
      m_wait = 0;
    end else if (!mcyc[m_owner]) begin
      m_owner = -1; m_abort = 0; m_first = 0; m_wait = 0;
    end else if (m_abort) begin
      m_first = 0;
    end else if (mstb[m_owner] && !sack && !serr) begin
      m_wait++;
      if (m_wait == TO - 1) begin
        m_abort = 1; m_first = 1; m_wait = 0;
      end
    end else begin
      m_wait = 0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    mcyc[m] = cyc; mstb[m] = stb; mwe[m] = we;
    maddr[m*AW +: AW] = a; mdata_w[m*DW +: DW] = d; msel[m*SW +: SW] = '1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mcyc = '0; mstb = '0; mwe = '0; maddr = '0; mdata_w = '0; msel = '0;
    sack = 1'b0; serr = 1'b0; sdata_r = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    set_m(0, 1, 1, 0, 30'h5, 32'h0);
    set_m(1, 1, 1, 0, 30'h6, 32'h0);
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || scyc !== 1'b0 || sstb !== 1'b0 || mack !== 2'b00 ||
        merr !== 2'b00 || tout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b scyc=%b sstb=%b mack=%b merr=%b tout=%b, want all 0",
               grant, scyc, sstb, mack, merr, tout);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_winner: grant=%b want 01", grant);
    end
    mcyc = '0; mstb = '0;
    step();
    step();
  endtask

  task automatic test_single_read();
    do_reset();
    set_m(0, 1, 1, 0, 30'h10, 32'h0);
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || scyc !== 1'b0) begin
      errors++;
      $display("FAIL read_arb_cycle: grant=%b scyc=%b want 00/0", grant, scyc);
    end
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || sstb !== 1'b1 || saddr !== 30'h10 || swe !== 1'b0 || mack !== 2'b00) begin
      errors++;
      $display("FAIL read_stb1: grant=%b sstb=%b saddr=%h swe=%b mack=%b want 01/1/10/0/00",
               grant, sstb, saddr, swe, mack);
    end
    step();
    sack = 1'b1; sdata_r = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (mack !== 2'b01 || mdata_r[DW-1:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_ack: mack=%b lane0=%h want 01/deadbeef", mack, mdata_r[DW-1:0]);
    end
    step();
    sack = 1'b0;
    set_m(0, 0, 0, 0, 30'h0, 32'h0);
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL read_release: grant=%b want 00", grant);
    end
    step();
  endtask

  task automatic test_contention();
    do_reset();
    set_m(0, 1, 1, 0, 30'h1, 32'h0);
    set_m(1, 1, 1, 0, 30'h2, 32'h0);
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL cont_first: grant=%b want 01", grant);
    end
    sack = 1'b1;
    step();
    sack = 1'b0;
    set_m(0, 0, 0, 0, 30'h0, 32'h0);
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL cont_dead_cycle: grant=%b want 00", grant);
    end
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL cont_second: grant=%b want 10", grant);
    end
    sack = 1'b1;
    step();
    sack = 1'b0;
    set_m(1, 0, 0, 0, 30'h0, 32'h0);
    step();
    set_m(0, 1, 1, 0, 30'h3, 32'h0);
    set_m(1, 1, 1, 0, 30'h4, 32'h0);
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL cont_rotate: grant=%b want 01", grant);
    end
    mcyc = '0; mstb = '0;
    step();
    step();
  endtask

  task automatic test_burst_hold();
    do_reset();
    set_m(1, 1, 1, 1, 30'h20, 32'hA000_0000);
    step();
    set_m(0, 1, 1, 0, 30'h99, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_m(1, 1, 1, 1, 30'h20 + 30'(i), 32'hA000_0000 + 32'(i));
      sack = 1'b1;
      @(negedge clk);
      checks++;
      if (grant !== 2'b10 || saddr !== 30'h20 + 30'(i) || swe !== 1'b1 || mack !== 2'b10 ||
          sdata_w !== 32'hA000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL burst_write%0d: grant=%b saddr=%h swe=%b mack=%b sdata=%h want 10/%h/1/10/%h",
                 i, grant, saddr, swe, mack, sdata_w, 30'h20 + 30'(i), 32'hA000_0000 + 32'(i));
      end
      step();
    end
    sack = 1'b0;
    set_m(1, 0, 0, 0, 30'h0, 32'h0);
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL burst_dead: grant=%b want 00", grant);
    end
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL burst_next_owner: grant=%b want 01", grant);
    end
    mcyc = '0; mstb = '0;
    step();
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    set_m(0, 1, 1, 0, 30'h44, 32'h0);
    step();
    for (int n = 1; n < TO; n++) begin
      @(negedge clk);
      checks++;
      if (sstb !== 1'b1 || merr !== 2'b00 || tout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait%0d: sstb=%b merr=%b tout=%b want 1/00/0", n, sstb, merr, tout);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (merr !== 2'b01 || tout !== 1'b1 || scyc !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: merr=%b tout=%b scyc=%b want 01/1/0", merr, tout, scyc);
    end
    step();
    @(negedge clk);
    checks++;
    if (merr !== 2'b00 || tout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_single_pulse: merr=%b tout=%b want 00/0", merr, tout);
    end
    step();
    sack = 1'b1;
    @(negedge clk);
    checks++;
    if (mack !== 2'b00) begin
      errors++;
      $display("FAIL timeout_late_ack: mack=%b want 00", mack);
    end
    step();
    sack = 1'b0;
    set_m(0, 0, 0, 0, 30'h0, 32'h0);
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL timeout_release: grant=%b want 00", grant);
    end
    step();
  endtask

  task automatic test_error();
    do_reset();
    set_m(1, 1, 1, 0, 30'h55, 32'h0);
    step();
    for (int n = 0; n < 10; n++) step();
    serr = 1'b1;
    @(negedge clk);
    checks++;
    if (merr !== 2'b10 || mack !== 2'b00) begin
      errors++;
      $display("FAIL err_passthru: merr=%b mack=%b want 10/00", merr, mack);
    end
    step();
    serr = 1'b0;
    for (int n = 0; n < TO - 2; n++) begin
      @(negedge clk);
      checks++;
      if (merr !== 2'b00 || tout !== 1'b0) begin
        errors++;
        $display("FAIL err_counter_cleared%0d: merr=%b tout=%b want 00/0", n, merr, tout);
      end
      step();
    end
    mcyc = '0; mstb = '0;
    step();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_m(0, 1, 1, 0, 30'h66, 32'h0);
    step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (scyc !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_drop: scyc=%b grant=%b want 0/00", scyc, grant);
    end
    model_reset();
    set_m(1, 1, 1, 0, 30'h67, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL async_reset_priority: grant=%b want 01", grant);
    end
    mcyc = '0; mstb = '0;
    step();
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int m = 0; m < NM; m++) begin
        if (mcyc[m]) begin
          if ($urandom_range(7) == 0) set_m(m, 0, 0, 0, 30'h0, 32'h0);
          else set_m(m, 1, ($urandom_range(3) != 0), 1'($urandom), 30'($urandom), $urandom);
        end else if ($urandom_range(2) == 0) begin
          set_m(m, 1, 1, 1'($urandom), 30'($urandom), $urandom);
        end
      end
      if ((cyc % 100) >= 60) begin
        sack = 1'b0; serr = 1'b0;
      end else begin
        sack = ($urandom_range(2) == 0);
        serr = ($urandom_range(15) == 0);
      end
      sdata_r = $urandom;
      @(negedge clk);
      model_expect();
      checks++;
      if (grant !== e_grant || scyc !== e_scyc || sstb !== e_sstb || mack !== e_mack ||
          merr !== e_merr || tout !== e_tout) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: grant=%b scyc=%b sstb=%b mack=%b merr=%b tout=%b want %b/%b/%b/%b/%b/%b",
                 cyc, grant, scyc, sstb, mack, merr, tout,
                 e_grant, e_scyc, e_sstb, e_mack, e_merr, e_tout);
      end
      if (e_scyc) begin
        checks++;
        if (saddr !== maddr[m_owner*AW +: AW] || sdata_w !== mdata_w[m_owner*DW +: DW] ||
            swe !== mwe[m_owner]) begin
          errors++;
          $display("FAIL rand_mux@%0d: saddr=%h sdata=%h swe=%b want %h/%h/%b", cyc, saddr, sdata_w,
                   swe, maddr[m_owner*AW +: AW], mdata_w[m_owner*DW +: DW], mwe[m_owner]);
        end
      end
      checks++;
      if (mdata_r !== {NM{sdata_r}}) begin
        errors++;
        $display("FAIL rand_rdata@%0d: mdata=%h want %h", cyc, mdata_r, {NM{sdata_r}});
      end
      step();
    end
    mcyc = '0; mstb = '0; sack = 1'b0; serr = 1'b0;
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit: run did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_burst_hold();
    test_timeout();
    test_error();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
